// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: times bits, drives the 3-cycle sampler window, deserialises and checks framing.
// Latency: data_valid pulses the cycle after the stop-bit end; no backpressure, the byte must be taken on the pulse.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled_bit,
    output logic                      sample_en,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [PRESCALE_WIDTH-1:0] p_q, p_d;
    logic [BCW-1:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      start_bit_q, start_bit_d;
    logic                      sample_en_q, sample_en_d;
    logic                      valid_q, valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic [PRESCALE_WIDTH-1:0] mid, mid_d;
    logic                      eob;
    logic                      capture;

    assign mid     = p_q >> 1;
    assign eob     = (edge_q == p_q - 1'b1);
    assign capture = (state_q != S_IDLE) && (edge_q == mid + 1'b1);

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        p_d         = p_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        p_data_d    = p_data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        start_bit_d = start_bit_q;
        valid_d     = 1'b0;
        par_err_d   = par_err_q;
        stp_err_d   = stp_err_q;

        if (state_q != S_IDLE) begin
            edge_d = eob ? '0 : edge_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!RX_IN) begin
                    state_d   = S_START;
                    p_d       = Prescale;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            S_START: begin
                if (capture) start_bit_d = sampled_bit;
                if (eob) begin
                    state_d = start_bit_q ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (capture) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                if (eob) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (capture && (sampled_bit != ((^shift_q) ^ par_typ_q))) par_err_d = 1'b1;
                if (eob) state_d = S_STOP;
            end
            S_STOP: begin
                if (capture && !sampled_bit) stp_err_d = 1'b1;
                if (eob) begin
                    // Capture precedes EOB, so both flags are final here.
                    if (!par_err_q && !stp_err_q) begin
                        p_data_d = shift_q;
                        valid_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered enable is derived from next-state values so it lines up with edge_q.
        mid_d       = p_d >> 1;
        sample_en_d = (state_d != S_IDLE) &&
                      (edge_d >= mid_d - 1'b1) && (edge_d <= mid_d + 1'b1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            edge_q      <= '0;
            p_q         <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            p_data_q    <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            start_bit_q <= 1'b0;
            sample_en_q <= 1'b0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            stp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            p_q         <= p_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            p_data_q    <= p_data_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            start_bit_q <= start_bit_d;
            sample_en_q <= sample_en_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            stp_err_q   <= stp_err_d;
        end
    end

    assign sample_en  = sample_en_q;
    assign P_DATA     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frame table, start glitch, back-to-back, mid-frame reset,
// then random frames scored against a frame-level model built from the line protocol rules.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit;
    logic       sample_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .sample_en   (sample_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 CLK = ~CLK;

    // Majority sampler: two registered samples plus the live line in the third enable cycle.
    logic [1:0] smp_q;
    always @(posedge CLK or negedge RST) begin
        if (!RST) smp_q <= 2'b00;
        else if (sample_en) smp_q <= {smp_q[0], RX_IN};
    end
    assign sampled_bit = (smp_q[1] & smp_q[0]) | (smp_q[1] & RX_IN) | (smp_q[0] & RX_IN);

    // Monitors, sampled on the falling edge.
    int cyc = 0;
    int se_cnt = 0, dv_cnt = 0, bad_runs = 0, run = 0;
    int last_dv = 0, prev_dv = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (!RST) begin
            run <= 0;
        end else begin
            if (sample_en) begin
                run    <= run + 1;
                se_cnt <= se_cnt + 1;
            end else if (run != 0) begin
                if (run != 3) bad_runs <= bad_runs + 1;
                run <= 0;
            end
            if (data_valid) begin
                dv_cnt  <= dv_cnt + 1;
                prev_dv <= last_dv;
                last_dv <= cyc;
            end
        end
    end

    int checks = 0, errors = 0;
    int se0, dv0, br0;
    logic [7:0] last_good;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mark();
        se0 = se_cnt;
        dv0 = dv_cnt;
        br0 = bad_runs;
    endtask

    // Frame-level reference: parity judged by total count of ones over data+parity bit.
    typedef struct {
        bit perr;
        bit serr;
        bit valid;
    } res_t;

    function automatic res_t model(input logic [7:0] data, input bit pen, input bit ptyp,
                                   input bit pbit, input bit stop);
        res_t r;
        int   ones;
        ones    = $countones(data) + int'(pbit);
        r.perr  = pen && ((ones % 2) != int'(ptyp));
        r.serr  = !stop;
        r.valid = !r.perr && !r.serr;
        return r;
    endfunction

    // Called on a falling edge; returns on the falling edge where the stop bit ends.
    task automatic send_frame(input string name, input int p, input bit pen, input bit ptyp,
                              input logic [7:0] data, input bit pbit, input bit stop,
                              input bit scramble);
        int legal[3];
        legal = '{8, 16, 32};
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        chk({name, "_flags_clr_at_start"}, {par_err, stp_err}, 2'b00);
        if (scramble) begin
            Prescale = 6'(legal[$urandom_range(2, 0)]);
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
        end
        repeat (p - 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (p) @(negedge CLK);
        end
        if (pen) begin
            RX_IN = pbit;
            repeat (p) @(negedge CLK);
        end
        RX_IN = stop;
        repeat (p) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    task automatic check_frame(input string name, input int exp_dv, input logic [7:0] exp_pdata,
                               input bit exp_perr, input bit exp_serr, input int exp_se);
        repeat (3) @(negedge CLK);
        chk({name, "_dv_pulses"}, dv_cnt - dv0, exp_dv);
        chk({name, "_pdata"}, P_DATA, exp_pdata);
        chk({name, "_par_err"}, par_err, exp_perr);
        chk({name, "_stp_err"}, stp_err, exp_serr);
        chk({name, "_sample_en_cycles"}, se_cnt - se0, exp_se);
        chk({name, "_sample_en_runs"}, bad_runs - br0, 0);
    endtask

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         pbit;
        bit         stop;
        int         exp_dv;
        logic [7:0] exp_pdata;
        bit         exp_perr;
        bit         exp_serr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 0, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{8,  1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1, 8'h0F, 1'b0, 1'b0};
        vecs[5] = '{32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{16, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8,  1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 0, 8'hFF, 1'b1, 1'b1};

        repeat (3) @(negedge CLK);
        chk("reset_outputs", {sample_en, P_DATA, data_valid, par_err, stp_err}, 12'h000);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_no_sample_en", sample_en, 1'b0);

        for (int i = 0; i < 8; i++) begin
            mark();
            send_frame($sformatf("vec%0d", i), vecs[i].p, vecs[i].pen, vecs[i].ptyp,
                       vecs[i].data, vecs[i].pbit, vecs[i].stop, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_dv, vecs[i].exp_pdata,
                        vecs[i].exp_perr, vecs[i].exp_serr, 3 * (10 + int'(vecs[i].pen)));
        end

        // Start glitch: two low cycles, then the line returns high.
        mark();
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        check_frame("glitch", 0, 8'hFF, 1'b0, 1'b0, 3);

        // Back-to-back frames at P=32, no idle gap on the line.
        mark();
        send_frame("b2b0", 32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        send_frame("b2b1", 32, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
        check_frame("b2b", 2, 8'hFE, 1'b0, 1'b0, 60);
        chk("b2b_gap_in_range", ((last_dv - prev_dv) >= 319) && ((last_dv - prev_dv) <= 321), 1'b1);

        // Reset in the middle of data bit 4, inside its sample window.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = 1'($urandom);
            repeat (8) @(negedge CLK);
        end
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        chk("pre_reset_sample_en", sample_en, 1'b1);
        RST = 1'b0;
        #1;
        chk("midframe_reset_outputs", {sample_en, P_DATA, data_valid, par_err, stp_err}, 12'h000);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        mark();
        send_frame("post_rst", 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        check_frame("post_rst", 1, 8'h81, 1'b0, 1'b0, 30);
        last_good = 8'h81;

        // Random frames, with config inputs disturbed mid-frame on some of them.
        for (int n = 0; n < 30; n++) begin
            int         p;
            bit         pen, ptyp, pbit, stop, scr;
            logic [7:0] data;
            res_t       r;
            int         legal[3];
            legal = '{8, 16, 32};
            p     = legal[$urandom_range(2, 0)];
            pen   = 1'($urandom);
            ptyp  = 1'($urandom);
            pbit  = 1'($urandom);
            stop  = ($urandom_range(3, 0) != 0);
            scr   = 1'($urandom);
            data  = 8'($urandom);
            r     = model(data, pen, ptyp, pbit, stop);
            if (r.valid) last_good = data;
            mark();
            send_frame($sformatf("rnd%0d", n), p, pen, ptyp, data, pbit, stop, scr);
            check_frame($sformatf("rnd%0d", n), r.valid ? 1 : 0, last_good, r.perr, r.serr,
                        3 * (10 + int'(pen)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
